// File: rtl/fd_grad_pkg.sv
// Shared types and constants for the forward-difference gradient requester.
// Operands are Q8.8, evaluator results and gradients are Q24.8.
package fd_grad_pkg;
  localparam int Q88_W  = 16;
  localparam int Q248_W = 32;

  localparam logic [Q88_W-1:0]  Q88_MAX = 16'h7FFF;
  localparam logic [Q248_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [Q248_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_RELEASE, S_CALC, S_DONE, S_ABORT
  } state_e;

  // Index 0..3 = a, b, c, d
  typedef logic [3:0][Q88_W-1:0] q88_vec_t;

  typedef struct packed {
    q88_vec_t ops;
    logic     sat;
  } perturb_t;

  // Operand set for evaluation idx: idx 1..4 nudges one coordinate by +step.
  // The step is positive, so only the positive rail can be crossed.
  function automatic perturb_t perturb(input q88_vec_t p, input logic [2:0] idx,
                                       input logic [Q88_W-1:0] step);
    perturb_t r;
    logic [Q88_W-1:0] s;
    r.ops = p;
    r.sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = p[i] + step;
      if (idx == 3'(i + 1)) begin
        if (!p[i][Q88_W-1] && s[Q88_W-1]) begin
          r.ops[i] = Q88_MAX;
          r.sat    = 1'b1;
        end else begin
          r.ops[i] = s;
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/fd_sat_shift.sv
// (fi - f0) <<< SHIFT with saturation to signed 32 bits.
// The difference is formed at 33 bits so it can never wrap before the shift.
module fd_sat_shift
  import fd_grad_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic [Q248_W-1:0] fi_i,
  input  logic [Q248_W-1:0] f0_i,
  output logic [Q248_W-1:0] grad_o,
  output logic              ovf_o
);
  localparam int XW = Q248_W + 1 + SHIFT;

  logic signed [Q248_W:0]  diff;
  logic signed [XW-1:0]    ext;
  logic signed [XW-1:0]    shf;
  logic [XW-Q248_W:0]      top;

  assign diff = $signed({fi_i[Q248_W-1], fi_i}) - $signed({f0_i[Q248_W-1], f0_i});
  assign ext  = diff;
  assign shf  = ext <<< SHIFT;
  // Fits in 32 bits only if everything above bit 30 is a copy of the sign
  assign top  = shf[XW-1:Q248_W-1];
  assign ovf_o = !((&top) || !(|top));
  assign grad_o = !ovf_o ? shf[Q248_W-1:0] : (shf[XW-1] ? SAT_MIN : SAT_MAX);
endmodule

// File: rtl/fd_grad_requester.sv
// Drives five evaluator transactions (f(p), then p + h*e_i for a..d) and
// produces the forward-difference gradient in Q24.8.
module fd_grad_requester
  import fd_grad_pkg::*;
#(
  parameter int H_SHIFT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [Q88_W-1:0]  a_in,
  input  logic [Q88_W-1:0]  b_in,
  input  logic [Q88_W-1:0]  c_in,
  input  logic [Q88_W-1:0]  d_in,
  output logic              busy,
  output logic              done,
  output logic [Q248_W-1:0] f0_out,
  output logic [Q248_W-1:0] grad_a,
  output logic [Q248_W-1:0] grad_b,
  output logic [Q248_W-1:0] grad_c,
  output logic [Q248_W-1:0] grad_d,
  output logic              coord_sat,
  output logic              grad_ovf,
  output logic              err,
  output logic              eval_start,
  output logic [Q88_W-1:0]  eval_a,
  output logic [Q88_W-1:0]  eval_b,
  output logic [Q88_W-1:0]  eval_c,
  output logic [Q88_W-1:0]  eval_d,
  input  logic [Q248_W-1:0] eval_z,
  input  logic              eval_done
);
  localparam logic [Q88_W-1:0] STEP     = Q88_W'(1) << (8 - H_SHIFT);
  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  state_e                   state_q;
  logic [2:0]               idx_q;
  logic [TW-1:0]            tmo_q;
  q88_vec_t                 pt_q, ops_q;
  logic [4:0][Q248_W-1:0]   f_q;
  logic [3:0][Q248_W-1:0]   grad_q, grad_w;
  logic [3:0]               ovf_w;
  logic [Q248_W-1:0]        f0_q;
  logic                     start_q, busy_q, done_q, err_q, csat_q, govf_q;
  perturb_t                 nxt;
  logic                     tmo_hit;

  assign nxt     = perturb(pt_q, idx_q + 3'd1, STEP);
  assign tmo_hit = (tmo_q == TMO_LAST) &&
                   ((state_q == S_ISSUE && !eval_done) || (state_q == S_RELEASE && eval_done));

  for (genvar g = 0; g < 4; g++) begin : g_sat
    fd_sat_shift #(.SHIFT(H_SHIFT)) u_sat (
      .fi_i  (f_q[g+1]),
      .f0_i  (f_q[0]),
      .grad_o(grad_w[g]),
      .ovf_o (ovf_w[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      pt_q    <= '0;
      ops_q   <= '0;
      f_q     <= '0;
      grad_q  <= '0;
      f0_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      csat_q  <= 1'b0;
      govf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          pt_q    <= {d_in, c_in, b_in, a_in};
          ops_q   <= {d_in, c_in, b_in, a_in};
          idx_q   <= '0;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          csat_q  <= 1'b0;
          govf_q  <= 1'b0;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (eval_done) begin
          f_q[idx_q] <= eval_z;
          start_q    <= 1'b0;
          tmo_q      <= '0;
          state_q    <= S_RELEASE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        // Next operands are loaded while the port is idle so they are
        // already settled a full cycle before start_func rises.
        S_RELEASE: if (!eval_done) begin
          if (idx_q == 3'd4) begin
            state_q <= S_CALC;
          end else begin
            idx_q   <= idx_q + 3'd1;
            ops_q   <= nxt.ops;
            csat_q  <= csat_q | nxt.sat;
            state_q <= S_SETUP;
          end
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_CALC: begin
          f0_q    <= f_q[0];
          grad_q  <= grad_w;
          govf_q  <= |ovf_w;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_ABORT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (tmo_hit) begin
        start_q <= 1'b0;
        err_q   <= 1'b1;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        grad_q  <= '0;
        f0_q    <= '0;
        state_q <= S_ABORT;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign f0_out     = f0_q;
  assign grad_a     = grad_q[0];
  assign grad_b     = grad_q[1];
  assign grad_c     = grad_q[2];
  assign grad_d     = grad_q[3];
  assign coord_sat  = csat_q;
  assign grad_ovf   = govf_q;
  assign err        = err_q;
  assign eval_start = start_q;
  assign eval_a     = ops_q[0];
  assign eval_b     = ops_q[1];
  assign eval_c     = ops_q[2];
  assign eval_d     = ops_q[3];
endmodule

// File: tb/tb_fd_grad_requester.sv
// Directed bench: behavioural evaluator (a-2)^2+(c+2)^2+(5d)^2+(b^2-5), L=6,
// one-cycle func_done tail, plus a handshake/operand-stability monitor.
module tb_fd_grad_requester;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic        busy, done, coord_sat, grad_ovf, err, eval_start, eval_done;
  logic [31:0] f0_out, grad_a, grad_b, grad_c, grad_d, eval_z;
  logic [15:0] eval_a, eval_b, eval_c, eval_d;

  int checks = 0, failures = 0;
  int mode = 0;  // 0 normal, 1 hang on eval 2, 2 f0=min/fi=max, 3 f0=max/fi=min
  localparam int L = 6;

  always #5 clk = ~clk;

  fd_grad_requester #(.H_SHIFT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .busy(busy), .done(done), .f0_out(f0_out),
    .grad_a(grad_a), .grad_b(grad_b), .grad_c(grad_c), .grad_d(grad_d),
    .coord_sat(coord_sat), .grad_ovf(grad_ovf), .err(err),
    .eval_start(eval_start),
    .eval_a(eval_a), .eval_b(eval_b), .eval_c(eval_c), .eval_d(eval_d),
    .eval_z(eval_z), .eval_done(eval_done)
  );

  function automatic logic [31:0] qmul(input logic signed [31:0] x, input logic signed [31:0] y);
    logic signed [63:0] p;
    p = 64'(x) * 64'(y);
    return p[39:8];
  endfunction

  function automatic logic [31:0] fmodel(input logic [15:0] a, b, c, d);
    logic signed [31:0] A, B, C, D, t1, t2, t3;
    A = 32'($signed(a)); B = 32'($signed(b)); C = 32'($signed(c)); D = 32'($signed(d));
    t1 = A - 32'sd512;
    t2 = C + 32'sd512;
    t3 = qmul(32'sd1280, D);
    return qmul(t1, t1) + qmul(t2, t2) + qmul(t3, t3) + qmul(B, B) - 32'd1280;
  endfunction

  // Evaluator: done rises L-1 edges after start rises, falls one edge after start drops
  int ev_st = 0, cnt = 0, ev_num = 0, cur = 0;
  always @(posedge clk) begin
    if (rst) begin
      ev_st <= 0; cnt <= 0; ev_num <= 0; cur <= 0;
      eval_done <= 1'b0; eval_z <= '0;
    end else begin
      if (!busy) ev_num <= 0;
      case (ev_st)
        0: if (eval_start) begin
          ev_st <= 1; cnt <= 1; cur <= ev_num; ev_num <= ev_num + 1;
        end
        1: if (!eval_start) ev_st <= 0;
           else if (cnt == L - 2) begin
             if (!(mode == 1 && cur == 2)) begin
               eval_done <= 1'b1;
               ev_st     <= 2;
               case (mode)
                 2:       eval_z <= (cur == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                 3:       eval_z <= (cur == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                 default: eval_z <= fmodel(eval_a, eval_b, eval_c, eval_d);
               endcase
             end
           end else cnt <= cnt + 1;
        default: if (!eval_start) begin eval_done <= 1'b0; ev_st <= 0; end
      endcase
    end
  end

  // Handshake monitor: log operands at each start rise, hold them stable in the window
  logic        prev_st = 1'b0;
  logic [63:0] cap = '0;
  logic [63:0] rise_ops[$];
  always @(negedge clk) begin
    if (eval_start && !prev_st) begin
      rise_ops.push_back({eval_d, eval_c, eval_b, eval_a});
      cap = {eval_d, eval_c, eval_b, eval_a};
      checks++;
      assert (eval_done === 1'b0) else begin
        failures++;
        $error("FAIL start_while_done observed=%b expected=0", eval_done);
      end
    end else if (eval_start || eval_done) begin
      checks++;
      assert ({eval_d, eval_c, eval_b, eval_a} === cap) else begin
        failures++;
        $error("FAIL ops_stable observed=%h expected=%h", {eval_d, eval_c, eval_b, eval_a}, cap);
      end
    end
    prev_st = eval_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; cyc counts the accept cycle through the first cycle done is seen
  task automatic run_req(input logic [15:0] a, b, c, d, output int cyc);
    a_in = a; b_in = b; c_in = c; d_in = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int cyc, base, n;
  logic [63:0] r;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_evstart", 32'(eval_start), 0);
    chk("rst_f0", f0_out, 0);
    chk("rst_grad_a", grad_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1/2: origin, latency and handshake count
    base = rise_ops.size();
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t1_latency", 32'(cyc), 32'd48);
    chk("t1_f0", f0_out, 32'h300);
    chk("t1_grad_a", grad_a, 32'(-1008));
    chk("t1_grad_b", grad_b, 32'd16);
    chk("t1_grad_c", grad_c, 32'd1040);
    chk("t1_grad_d", grad_d, 32'd400);
    chk("t1_err", 32'(err), 0);
    chk("t1_csat", 32'(coord_sat), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_rises", 32'(rise_ops.size() - base), 32'd5);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);

    // 3: coordinate saturation on the a perturbation
    base = rise_ops.size();
    run_req(16'h7FF8, 16'h0, 16'h0, 16'h0, cyc);
    r = (rise_ops.size() > base + 1) ? rise_ops[base+1] : '1;
    chk("t3_eval_a", 32'(r[15:0]), 32'h7FFF);
    chk("t3_eval_bc", r[47:16], 0);
    chk("t3_eval_d", 32'(r[63:48]), 0);
    chk("t3_csat", 32'(coord_sat), 1);
    chk("t3_grad_a", grad_a, 32'd28224);
    chk("t3_grad_b", grad_b, 32'd16);
    @(negedge clk);
    chk("t3_done_pulse", 32'(done), 0);

    // 4: evaluator hangs on idx 2 -> abort, then a clean rerun
    mode = 1;
    base = rise_ops.size();
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t4_err", 32'(err), 1);
    chk("t4_f0", f0_out, 0);
    chk("t4_grad_a", grad_a, 0);
    chk("t4_grad_d", grad_d, 0);
    chk("t4_evstart", 32'(eval_start), 0);
    chk("t4_rises", 32'(rise_ops.size() - base), 32'd3);
    @(negedge clk);
    chk("t4_done_pulse", 32'(done), 0);
    mode = 0;
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t4_rerun_err", 32'(err), 0);
    chk("t4_rerun_f0", f0_out, 32'h300);
    chk("t4_rerun_grad_c", grad_c, 32'd1040);
    @(negedge clk);

    // 5: reset during ISSUE of idx 3
    base = rise_ops.size();
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rise_ops.size() < base + 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_idx3", 32'(rise_ops.size() >= base + 4), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_evstart", 32'(eval_start), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_f0", f0_out, 0);
    chk("t5_grad_a", grad_a, 0);
    chk("t5_done", 32'(done), 0);
    @(negedge clk);
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t5_latency", 32'(cyc), 32'd48);
    chk("t5_f0_after", f0_out, 32'h300);
    chk("t5_grad_a_after", grad_a, 32'(-1008));
    chk("t5_grad_d_after", grad_d, 32'd400);
    @(negedge clk);

    // 6: gradient saturation both ways
    mode = 2;
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t6_f0", f0_out, 32'h8000_0000);
    chk("t6_grad_a", grad_a, 32'h7FFF_FFFF);
    chk("t6_ovf", 32'(grad_ovf), 1);
    @(negedge clk);
    mode = 3;
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t6_neg_grad_d", grad_d, 32'h8000_0000);
    chk("t6_neg_ovf", 32'(grad_ovf), 1);
    @(negedge clk);
    mode = 0;
    run_req(16'h0, 16'h0, 16'h0, 16'h0, cyc);
    chk("t6_ovf_clear", 32'(grad_ovf), 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
